// File: rtl/softplus_pkg.sv
// Shared Q8.8 constants and piecewise-linear SoftPlus offset tables.
package softplus_pkg;

  localparam int unsigned Q_W = 16;
  localparam logic [Q_W-1:0] SAT_MAX = 16'h7FFF;

  typedef logic [Q_W-1:0] q88_t;

  // Index 0..4 covers integer parts 0..4 (positive side) or -1..-5 (negative side); 5 is "beyond".
  function automatic q88_t offp(input logic [2:0] idx);
    case (idx)
      3'd0:    offp = 16'h004D;
      3'd1:    offp = 16'h0037;
      3'd2:    offp = 16'h001F;
      3'd3:    offp = 16'h0010;
      3'd4:    offp = 16'h000B;
      default: offp = 16'h0009;
    endcase
  endfunction

  function automatic q88_t offn(input logic [2:0] idx);
    case (idx)
      3'd0:    offn = 16'h004D;
      3'd1:    offn = 16'h0037;
      3'd2:    offn = 16'h001F;
      3'd3:    offn = 16'h000F;
      3'd4:    offn = 16'h0007;
      default: offn = 16'h0002;
    endcase
  endfunction

endpackage

// File: rtl/softplus_pwl_eval.sv
// Combinational Q8.8 SoftPlus: ReLU plus per-segment offset, saturated to SAT_MAX.
module softplus_pwl_eval
  import softplus_pkg::*;
(
  input  logic [Q_W-1:0] x,
  output logic [Q_W-1:0] y
);

  logic [7:0]     seg_mag;
  logic [2:0]     idx;
  logic [Q_W:0]   sum;

  always_comb begin
    // For negative x, ~seg maps -1..-5 onto 0..4, sharing one index decode with the positive side.
    seg_mag = x[15] ? ~x[15:8] : x[15:8];
    idx     = (seg_mag < 8'd5) ? seg_mag[2:0] : 3'd5;
    sum     = {1'b0, x} + {1'b0, offp(idx)};
    if (x[15])
      y = offn(idx);
    else if (sum > {1'b0, SAT_MAX})
      y = SAT_MAX;
    else
      y = sum[Q_W-1:0];
  end

endmodule

// File: rtl/softplus_rr_sched.sv
// Round-robin scheduler feeding a shared 2-stage SoftPlus pipeline with an id-tagged response.
module softplus_rr_sched
  import softplus_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [16*NUM_REQ-1:0]      req_operand,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [15:0]                rsp_result,
  output logic                       idle,
  output logic [CNT_W-1:0]           done_cnt
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0] rr_ptr;
  logic            s1_v, s2_v;
  logic [ID_W-1:0] s1_id, s2_id;
  logic [Q_W-1:0]  s1_x, s2_y;
  logic [Q_W-1:0]  eval_y;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [Q_W-1:0]  gnt_x;
  logic            s1_load, s2_load, accept;

  softplus_pwl_eval u_eval (
    .x (s1_x),
    .y (eval_y)
  );

  assign s2_load = !s2_v || rsp_ready;
  assign s1_load = !s1_v || s2_load;

  // Two ascending passes (indices above rr_ptr, then the rest) implement the rotated priority search.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_x     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (i > 32'(rr_ptr))) begin
        gnt_found = 1'b1;
        gnt_id    = i[ID_W-1:0];
        gnt_x     = req_operand[16*i +: 16];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (i <= 32'(rr_ptr))) begin
        gnt_found = 1'b1;
        gnt_id    = i[ID_W-1:0];
        gnt_x     = req_operand[16*i +: 16];
      end
    end
  end

  assign accept    = en && !rst && s1_load && gnt_found;
  assign req_ready = accept ? (NUM_REQ'(1) << gnt_id) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= ID_W'(NUM_REQ - 1);
      s1_v     <= 1'b0;
      s1_id    <= '0;
      s1_x     <= '0;
      s2_v     <= 1'b0;
      s2_id    <= '0;
      s2_y     <= '0;
      done_cnt <= '0;
    end else begin
      if (accept)
        rr_ptr <= gnt_id;
      if (s1_load) begin
        s1_v <= accept;
        if (accept) begin
          s1_id <= gnt_id;
          s1_x  <= gnt_x;
        end
      end
      if (s2_load) begin
        s2_v <= s1_v;
        if (s1_v) begin
          s2_id <= s1_id;
          s2_y  <= eval_y;
        end
      end
      if (s2_v && rsp_ready)
        done_cnt <= done_cnt + CNT_W'(1);
    end
  end

  assign rsp_valid  = s2_v;
  assign rsp_id     = s2_id;
  assign rsp_result = s2_y;
  assign idle       = !s1_v && !s2_v;

endmodule

// File: tb/tb_softplus_rr_sched.sv
// Directed bench: table-driven evaluation vectors plus arbitration/backpressure/reset sequences.
module tb_softplus_rr_sched;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_operand;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_result;
  logic        idle;
  logic [15:0] done_cnt;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
  } vec_t;

  vec_t        vt [16];
  logic [15:0] op_x [4];
  logic [15:0] op_y [4];

  // Occupancy / arbitration model for the sequence tests
  logic        m_s1, m_s2;
  int unsigned m_s1_id, m_s2_id, m_ptr;
  logic [15:0] m_done;
  int          cnt [4];

  softplus_rr_sched #(.NUM_REQ(4), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_operand (req_operand),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .idle        (idle),
    .done_cnt    (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0;
    m_s1_id = 0; m_s2_id = 0;
    m_ptr = 3; m_done = 16'h0000;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  task automatic check_reset_state();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_done_cnt", 32'(done_cnt), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0000;
    @(posedge clk); @(posedge clk); #1;
    check_reset_state();
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  // One cycle: drive vmask, check all outputs against the model, then advance the model.
  task automatic step(input logic [3:0] vmask);
    logic        s2_ld, s1_ld, found, acc;
    int unsigned g, idx;
    logic [3:0]  er;
    req_valid = vmask;
    #1;
    s2_ld = !m_s2 || rsp_ready;
    s1_ld = !m_s1 || s2_ld;
    found = 1'b0; g = 0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (!found && vmask[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
    acc = en && s1_ld && found;
    er  = acc ? 4'(1 << g) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_s2));
    if (m_s2) begin
      chk("rsp_id", 32'(rsp_id), m_s2_id);
      chk("rsp_result", 32'(rsp_result), 32'(op_y[m_s2_id]));
    end
    chk("idle", 32'(idle), 32'(!(m_s1 || m_s2)));
    chk("done_cnt", 32'(done_cnt), 32'(m_done));
    if (m_s2 && rsp_ready) begin
      m_done = m_done + 16'd1;
      cnt[m_s2_id]++;
    end
    if (s2_ld) begin
      m_s2 = m_s1;
      m_s2_id = m_s1_id;
    end
    if (s1_ld) begin
      m_s1 = acc;
      if (acc) m_s1_id = g;
    end
    if (acc) m_ptr = g;
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned id;
    n_chk = 0; n_fail = 0;
    rst = 1'b1; en = 1'b1; rsp_ready = 1'b1; req_valid = 4'b0000; req_operand = '0;

    vt[0]  = '{16'h0000, 16'h004D};
    vt[1]  = '{16'h0180, 16'h01B7};
    vt[2]  = '{16'hFF00, 16'h004D};
    vt[3]  = '{16'hFB80, 16'h0007};
    vt[4]  = '{16'h8000, 16'h0002};
    vt[5]  = '{16'h0A00, 16'h0A09};
    vt[6]  = '{16'h7FF8, 16'h7FFF};
    vt[7]  = '{16'h0200, 16'h021F};
    vt[8]  = '{16'h0300, 16'h0310};
    vt[9]  = '{16'h0400, 16'h040B};
    vt[10] = '{16'hFE80, 16'h0037};
    vt[11] = '{16'hFD00, 16'h001F};
    vt[12] = '{16'hFC40, 16'h000F};
    vt[13] = '{16'h7FF6, 16'h7FFF};
    vt[14] = '{16'h00FF, 16'h014C};
    vt[15] = '{16'hFA00, 16'h0002};

    op_x[0] = 16'h0180; op_y[0] = 16'h01B7;
    op_x[1] = 16'hFF00; op_y[1] = 16'h004D;
    op_x[2] = 16'h0A00; op_y[2] = 16'h0A09;
    op_x[3] = 16'h7FF8; op_y[3] = 16'h7FFF;

    // Evaluation table: single request, 2-cycle latency, id tag
    do_reset();
    for (int i = 0; i < 16; i++) begin
      id = i % 4;
      req_operand = '0;
      req_operand[16*id +: 16] = vt[i].x;
      req_valid = 4'(1 << id);
      #1;
      chk("tbl_accept", 32'(req_ready), 32'(1 << id));
      @(posedge clk); #1;
      req_valid = 4'b0000;
      chk("tbl_lat_n1", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("tbl_rsp_id", 32'(rsp_id), id);
      chk("tbl_result", 32'(rsp_result), 32'(vt[i].y));
      @(posedge clk); #1;
    end
    chk("tbl_done_cnt", 32'(done_cnt), 32'd16);

    for (int i = 0; i < 4; i++) req_operand[16*i +: 16] = op_x[i];

    // All requesters valid: rotating grants, one response per cycle, fair share
    do_reset();
    for (int c = 0; c < 18; c++) step(4'hF);
    for (int i = 0; i < 4; i++) chk("fair_share", 32'(cnt[i]), 32'd4);
    step(4'h0); step(4'h0); step(4'h0);
    chk("rr_done_cnt", 32'(done_cnt), 32'd18);

    // Backpressure: 5 stalled cycles with a full pipeline
    do_reset();
    for (int c = 0; c < 4; c++) step(4'hF);
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) step(4'hF);
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) step(4'hF);
    step(4'h0); step(4'h0); step(4'h0);
    chk("bp_idle", 32'(idle), 32'd1);

    // en low with two ops in flight: drain, then resume after the last grant
    do_reset();
    step(4'hF); step(4'hF);
    en = 1'b0;
    step(4'hF); step(4'hF); step(4'hF);
    chk("en_idle", 32'(idle), 32'd1);
    chk("en_drain_cnt", 32'(done_cnt), 32'd2);
    en = 1'b1;
    req_valid = 4'hF;
    #1;
    chk("en_resume", 32'(req_ready), 32'b0100);
    step(4'hF); step(4'h0); step(4'h0); step(4'h0);

    // Asynchronous reset mid-cycle with a full pipeline
    do_reset();
    for (int c = 0; c < 4; c++) step(4'hF);
    #2;
    rst = 1'b1;
    req_valid = 4'h0;
    #1;
    check_reset_state();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    step(4'b0110);
    step(4'b0000);

    // Counter wrap from 0xFFFF
    force dut.done_cnt = 16'hFFFF;
    #1;
    release dut.done_cnt;
    m_done = 16'hFFFF;
    chk("wrap_preload", 32'(done_cnt), 32'h0000FFFF);
    step(4'b0000);
    step(4'b0000);
    chk("wrap_zero", 32'(done_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
